alu_logic_issuer: RTL and testbench

ALU_LOGIC_ISSUER -- requirements
Module: alu_logic_issuer

---
 rtl/alu_logic_issuer.sv | 155 +++++++++++++++
 tb/tb_alu_logic_issuer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_logic_issuer.sv
// rtl/alu_logic_issuer.sv - issues operands to an external logic gate bank and returns the selected result
//
// Purpose: accepts one logic-op request at a time, drives the registered operands
// onto the gate bank, waits SETTLE_CYCLES clocks for the bank to settle, then
// captures the result selected by the op code and holds it until consumed.
// Invalid op codes (5-7) skip the gate bank and answer at once with rsp_err=1.
//
// Optional build macro: ALU_ISSUER_ZERO_FLAG_EN adds rsp_zero (result==0 and no error).
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_op, req_a, req_b            op code (0 AND,1 NAND,2 OR,3 NOR,4 XOR) and operands
//   gate_a, gate_b                  registered operands to the gate bank
//   and_in..xor_in                  gate bank results
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_err             captured result, invalid-op flag
//   rsp_zero                        zero flag (only with ALU_ISSUER_ZERO_FLAG_EN)

module alu_logic_issuer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] gate_a,
  output logic [31:0] gate_b,
  input  logic [31:0] and_in,
  input  logic [31:0] nand_in,
  input  logic [31:0] or_in,
  input  logic [31:0] nor_in,
  input  logic [31:0] xor_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err
`ifdef ALU_ISSUER_ZERO_FLAG_EN
  ,
  output logic        rsp_zero
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic        accept;
  logic        capture;
  logic        op_valid;
  logic [31:0] sel;

  assign op_valid = (req_op <= 3'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        // State already reads IDLE during reset; gate with rst_n so no request
        // is advertised while the block is held in reset.
        req_ready = rst_n;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = op_valid ? SETTLE : RESP;
        end
      end
      SETTLE: begin
        // Counter value 1 means this edge takes it to 0: sample now.
        if (cnt_q <= 4'd1) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel = '0;
    case (op_q)
      3'd0:    sel = and_in;
      3'd1:    sel = nand_in;
      3'd2:    sel = or_in;
      3'd3:    sel = nor_in;
      3'd4:    sel = xor_in;
      default: sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      op_q       <= '0;
      gate_a     <= '0;
      gate_b     <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept && op_valid) begin
        gate_a <= req_a;
        gate_b <= req_b;
        op_q   <= req_op;
        cnt_q  <= SETTLE_INIT;
      end
      if (accept && !op_valid) begin
        rsp_result <= '0;
        rsp_err    <= 1'b1;
      end
      if (state_q == SETTLE) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        rsp_result <= sel;
        rsp_err    <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUER_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_zero <= 1'b0;
    end else if (accept && !op_valid) begin
      rsp_zero <= 1'b0;
    end else if (capture) begin
      rsp_zero <= (sel == 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_alu_logic_issuer.sv
// tb/tb_alu_logic_issuer.sv - self-checking bench for alu_logic_issuer

module tb_alu_logic_issuer;

  localparam int S = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [31:0] gate_a, gate_b;
  logic [31:0] and_in, nand_in, or_in, nor_in, xor_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;
`ifdef ALU_ISSUER_ZERO_FLAG_EN
  logic        rsp_zero;
`endif

  int total_checks;
  int passed_checks;

  // model of the architectural operand registers seen by the gate bank
  logic [31:0] mdl_ga, mdl_gb;

  alu_logic_issuer #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .gate_a(gate_a), .gate_b(gate_b),
    .and_in(and_in), .nand_in(nand_in), .or_in(or_in), .nor_in(nor_in), .xor_in(xor_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
`ifdef ALU_ISSUER_ZERO_FLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );

  // combinational gate bank
  assign and_in  = gate_a & gate_b;
  assign nand_in = ~(gate_a & gate_b);
  assign or_in   = gate_a | gate_b;
  assign nor_in  = ~(gate_a | gate_b);
  assign xor_in  = gate_a ^ gate_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    if (obs === exp) passed_checks++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return ~(a & b);
      3'd2:    return a | b;
      3'd3:    return ~(a | b);
      3'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic do_txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit keep);
    logic [31:0] exp_res;
    logic        exp_err;
    bit          valid;
    int          lat;
    valid     = (op <= 3'd4);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = (hold == 0);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
    req_a  = $urandom;
    req_b  = $urandom;
    req_op = 3'($urandom_range(0, 7));
    if (valid) begin
      mdl_ga  = a;
      mdl_gb  = b;
      exp_res = ref_op(op, a, b);
      exp_err = 1'b0;
    end else begin
      exp_res = 32'd0;
      exp_err = 1'b1;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid) check("busy_ready", 32'(req_ready), 32'd0);
    end while (!rsp_valid && lat < 40);
    check("latency", 32'(lat), valid ? 32'(S + 1) : 32'd1);
    check("result", rsp_result, exp_res);
    check("err", 32'(rsp_err), 32'(exp_err));
    check("gate_a", gate_a, mdl_ga);
    check("gate_b", gate_b, mdl_gb);
`ifdef ALU_ISSUER_ZERO_FLAG_EN
    check("zero", 32'(rsp_zero), 32'(!exp_err && exp_res == 32'd0));
`endif
    for (int i = 0; i < hold; i++) begin
      req_a  = $urandom;
      req_b  = $urandom;
      req_op = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_result", rsp_result, exp_res);
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_gate_a", gate_a, mdl_ga);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    mdl_ga = 32'd0;
    mdl_gb = 32'd0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_a = 32'd0;
    req_b = 32'd0;
    rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_gate_a", gate_a, 32'd0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // directed cases
    do_txn(3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 1'b0);
    do_txn(3'd3, 32'h00000000, 32'h0000FFFF, 5, 1'b0);
    do_txn(3'd6, 32'hDEADBEEF, 32'h12345678, 0, 1'b0);
    do_txn(3'd4, 32'h12345678, 32'h12345678, 1, 1'b0);
    do_txn(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    do_txn(3'd7, 32'hFFFFFFFF, 32'h00000000, 2, 1'b0);

    // back-to-back with req_valid held high
    do_txn(3'd0, 32'hA5A5A5A5, 32'h0F0F0F0F, 0, 1'b1);
    do_txn(3'd2, 32'h11110000, 32'h00002222, 0, 1'b1);
    do_txn(3'd4, 32'hCAFEF00D, 32'h0BADF00D, 0, 1'b0);
    req_valid = 1'b0;

    // reset in the middle of SETTLE for an OR request
    req_valid = 1'b1;
    req_op = 3'd2;
    req_a = 32'h13572468;
    req_b = 32'h80000001;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    mdl_ga = 32'd0;
    mdl_gb = 32'd0;
    check("abort_gate_a", gate_a, 32'd0);
    check("abort_gate_b", gate_b, 32'd0);
    check("abort_result", rsp_result, 32'd0);
    check("abort_err", 32'(rsp_err), 32'd0);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
`ifdef ALU_ISSUER_ZERO_FLAG_EN
    check("abort_zero", 32'(rsp_zero), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("abort_rel_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // invalid op right after reset leaves the zeroed gates alone
    do_txn(3'd5, 32'h55555555, 32'hAAAAAAAA, 0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      do_txn(3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
